ysyx_25070198_lsu: RTL

YSYX_25070198_LSU -- requirements
Module: ysyx_25070198_lsu

---
 rtl/ysyx_25070198_lsu.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ysyx_25070198_lsu.sv
// Load/store unit: single-outstanding EXU-to-memory bridge with byte-lane steering,
// load sign/zero extension, alignment checking and a REQ+WAIT timeout.
module ysyx_25070198_lsu #(
  parameter int XLEN    = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_wen,
  output logic [AW-1:0]     mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [1:0]        dbg_state
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // the initiator holds valid and payload stable until that edge.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic            wen_q;
  logic            uns_q;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [1:0]      size_q;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rdata_q;
  logic            err_q;

  logic            accept;
  logic            misaligned;
  logic            illegal;
  logic            bad_req;
  logic            expired;
  logic            got_rdata;
  logic [OW-1:0]   off;
  logic [NB-1:0]   size_mask;
  logic [XLEN-1:0] rd_shift;
  logic [XLEN-1:0] rd_mask;
  logic            rd_sign;
  logic [XLEN-1:0] load_data;

  always_comb begin
    case (req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = req_addr[0];
      2'd2:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign illegal   = (req_size == 2'd3) && (XLEN == 32);
  assign bad_req   = misaligned || illegal;
  assign accept    = req_valid && req_ready;
  assign expired   = (TIMEOUT != 0) && (cnt >= TO_LAST);
  assign got_rdata = (state == S_WAIT) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // A completed handshake wins over an expiring timeout in the same cycle, so a
  // request the memory has already taken is never silently dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req_valid) state_nxt = bad_req ? S_RESP : S_REQ;
      S_REQ: begin
        if (mem_ready)    state_nxt = S_WAIT;
        else if (expired) state_nxt = S_RESP;
      end
      S_WAIT: begin
        if (mem_rvalid)   state_nxt = S_RESP;
        else if (expired) state_nxt = S_RESP;
      end
      S_RESP: if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wen_q   <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= 2'd0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        cnt     <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
        cnt <= cnt + 1'b1;
      end

      // Response is captured on entry to RESP; anything but read data is an error.
      if (state != S_RESP && state_nxt == S_RESP) begin
        rdata_q <= (got_rdata && !wen_q) ? load_data : '0;
        err_q   <= !got_rdata;
      end else if (state == S_RESP && rsp_ready) begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  assign off = addr_q[OW-1:0];

  always_comb begin
    case (size_q)
      2'd0:    size_mask = NB'(4'h1);
      2'd1:    size_mask = NB'(4'h3);
      2'd2:    size_mask = NB'(4'hF);
      default: size_mask = NB'(8'hFF);
    endcase
  end

  // Load path: bring the addressed lane down to bit 0, keep the access width and
  // fill the rest with the sign bit or zeros.
  assign rd_shift = mem_rdata >> {off, 3'b000};

  always_comb begin
    case (size_q)
      2'd0: begin
        rd_mask = XLEN'(8'hFF);
        rd_sign = rd_shift[7];
      end
      2'd1: begin
        rd_mask = XLEN'(16'hFFFF);
        rd_sign = rd_shift[15];
      end
      2'd2: begin
        rd_mask = XLEN'(32'hFFFF_FFFF);
        rd_sign = rd_shift[31];
      end
      default: begin
        rd_mask = '1;
        rd_sign = rd_shift[XLEN-1];
      end
    endcase
  end

  assign load_data = (rd_shift & rd_mask) | ({XLEN{rd_sign & ~uns_q}} & ~rd_mask);

  // Control outputs are forced low while reset is held, not just after the edge.
  assign req_ready = rst && (state == S_IDLE);
  assign mem_valid = rst && (state == S_REQ);
  assign mem_wen   = mem_valid && wen_q;
  assign mem_addr  = addr_q & ~AW'(NB - 1);
  assign mem_wdata = wdata_q << {off, 3'b000};
  assign mem_wmask = mem_wen ? (size_mask << off) : '0;
  assign rsp_valid = rst && (state == S_RESP);
  assign rsp_rdata = rst ? rdata_q : '0;
  assign rsp_err   = rst && err_q;
  assign dbg_state = state;

endmodule
